// File: rtl/seq_mult_pkg.sv
// Shared state encoding and sizing helpers for the sequential digit multiplier.
package seq_mult_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Step counter width; a single-step configuration still needs one bit.
    function automatic int unsigned count_w(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_digit.sv
// Combinational DIG_W x DIG_W unsigned digit multiplier.
module seq_mult_digit #(
    parameter int unsigned DIG_W = 4
) (
    input  logic [DIG_W-1:0]   i_a,
    input  logic [DIG_W-1:0]   i_b,
    output logic [2*DIG_W-1:0] o_p
);

    localparam int unsigned P_W = 2 * DIG_W;

    assign o_p = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/seq_mult_core.sv
// Sequential multiplier: one digit-pair partial product accumulated per cycle.
// Optional two's-complement operands when SEQ_MULT_SIGNED_MODE_EN is defined.
module seq_mult_core
    import seq_mult_pkg::*;
#(
    parameter  int unsigned OP_W  = 8,
    parameter  int unsigned DIG_W = 4,
    localparam int unsigned N     = OP_W / DIG_W,
    localparam int unsigned STEPS = N * N,
    localparam int unsigned CNT_W = count_w(STEPS)
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic [OP_W-1:0]    dataa,
    input  logic [OP_W-1:0]    datab,
`ifdef SEQ_MULT_SIGNED_MODE_EN
    input  logic               signed_op,
`endif
    output logic [2*OP_W-1:0]  product,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic [STATE_W-1:0] state_out,
    output logic [CNT_W-1:0]   count_out
);

    localparam int unsigned ACC_W = 2 * OP_W;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [OP_W-1:0]        r_a;
    logic [OP_W-1:0]        r_b;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_k;
    logic [ACC_W-1:0]       r_product;
    logic                   r_err;
    logic                   r_neg;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_neg;
    logic [OP_W-1:0]        w_mag_a;
    logic [OP_W-1:0]        w_mag_b;
    int unsigned            w_i;
    int unsigned            w_j;
    logic [DIG_W-1:0]       w_a_dig;
    logic [DIG_W-1:0]       w_b_dig;
    logic [2*DIG_W-1:0]     w_pp;
    logic [ACC_W-1:0]       w_acc_next;
    logic [ACC_W-1:0]       w_result;

    // ---------------- Controller ----------------
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC: begin
                if (start) begin
                    w_state_next = ERR;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = start ? CALC : IDLE;
            ERR:     if (start) w_state_next = CALC;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = start && (r_state != CALC);
    assign w_last   = (r_k == CNT_W'(STEPS - 1));

    // ---------------- Operand conditioning ----------------
`ifdef SEQ_MULT_SIGNED_MODE_EN
    // Magnitudes of -2^(OP_W-1) still fit, so the datapath stays unsigned.
    always_comb begin
        w_mag_a = dataa;
        w_mag_b = datab;
        w_neg   = 1'b0;
        if (signed_op) begin
            if (dataa[OP_W-1]) w_mag_a = ~dataa + OP_W'(1);
            if (datab[OP_W-1]) w_mag_b = ~datab + OP_W'(1);
            w_neg = dataa[OP_W-1] ^ datab[OP_W-1];
        end
    end
    assign w_result = r_neg ? (~w_acc_next + ACC_W'(1)) : w_acc_next;
`else
    assign w_mag_a  = dataa;
    assign w_mag_b  = datab;
    assign w_neg    = 1'b0;
    assign w_result = w_acc_next;
`endif

    // ---------------- Datapath ----------------
    always_comb begin
        w_i        = 32'(r_k) % N;
        w_j        = 32'(r_k) / N;
        w_a_dig    = DIG_W'(r_a >> (w_i * DIG_W));
        w_b_dig    = DIG_W'(r_b >> (w_j * DIG_W));
        w_acc_next = r_acc + (ACC_W'(w_pp) << ((w_i + w_j) * DIG_W));
    end

    seq_mult_digit #(
        .DIG_W (DIG_W)
    ) u_digit (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_k       <= '0;
            r_product <= '0;
            r_err     <= 1'b0;
            r_neg     <= 1'b0;
        end else if (w_accept) begin
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_neg <= w_neg;
            r_acc <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
        end else if (r_state == CALC) begin
            if (start) begin
                // Abort: partial sum is dropped, held product untouched.
                r_err <= 1'b1;
                r_acc <= '0;
                r_k   <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_k   <= r_k + CNT_W'(1);
                if (w_last) begin
                    r_product <= w_result;
                    r_k       <= '0;
                end
            end
        end
    end

    assign product   = r_product;
    assign done      = (r_state == DONE);
    assign busy      = (r_state == CALC);
    assign err       = r_err;
    assign state_out = r_state;
    assign count_out = (r_state == CALC) ? r_k : '0;

endmodule

// File: tb/tb_seq_mult_core.sv
// Directed self-checking bench for seq_mult_core (8x8/4 and 16x16/4 instances).
module tb_seq_mult_core;

    logic        clk = 1'b0;
    logic        reset_a;

    // 8-bit instance
    logic        start;
    logic [7:0]  dataa, datab;
    logic [15:0] product;
    logic        done, busy, err;
    logic [1:0]  state_out;
    logic [1:0]  count_out;

    // 16-bit instance
    logic        w_start;
    logic [15:0] w_dataa, w_datab;
    logic [31:0] w_product;
    logic        w_done, w_busy, w_err;
    logic [1:0]  w_state_out;
    logic [3:0]  w_count_out;

`ifdef SEQ_MULT_SIGNED_MODE_EN
    logic        signed_op;
    logic        w_signed_op;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_core #(
        .OP_W  (8),
        .DIG_W (4)
    ) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
`ifdef SEQ_MULT_SIGNED_MODE_EN
        .signed_op (signed_op),
`endif
        .product   (product),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .state_out (state_out),
        .count_out (count_out)
    );

    seq_mult_core #(
        .OP_W  (16),
        .DIG_W (4)
    ) dut_w (
        .clk       (clk),
        .reset_a   (reset_a),
        .start     (w_start),
        .dataa     (w_dataa),
        .datab     (w_datab),
`ifdef SEQ_MULT_SIGNED_MODE_EN
        .signed_op (w_signed_op),
`endif
        .product   (w_product),
        .done      (w_done),
        .busy      (w_busy),
        .err       (w_err),
        .state_out (w_state_out),
        .count_out (w_count_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge with the DUT in CALC, k=0.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walk the 4 CALC cycles, ending at the negedge of the DONE cycle.
    task automatic calc_to_done(input string tag, input logic [15:0] exp_prod);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_count"}, 64'(count_out), 64'(k));
            check({tag, "_nodone"}, 64'(done), 64'd0);
            // Operand changes after start must not matter.
            dataa = 8'h5A;
            datab = 8'hC3;
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_dbusy"}, 64'(busy), 64'd0);
        check({tag, "_dstate"}, 64'(state_out), 64'd2);
        check({tag, "_product"}, 64'(product), 64'(exp_prod));
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic back_to_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
        check({tag, "_idle_state"}, 64'(state_out), 64'd0);
    endtask

    initial begin
        reset_a = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        w_start = 1'b0;
        w_dataa = '0;
        w_datab = '0;
`ifdef SEQ_MULT_SIGNED_MODE_EN
        signed_op   = 1'b0;
        w_signed_op = 1'b0;
`endif
        #3;
        check("rst_product", 64'(product), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(state_out), 64'd0);
        check("rst_count", 64'(count_out), 64'd0);
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);
        check("idle_wait", 64'(state_out), 64'd0);

        // 1: 0xFF x 0xFF
        start_op(8'hFF, 8'hFF);
        calc_to_done("t1", 16'hFE01);
        back_to_idle("t1");

        // 2: zero operand, then 12 x 13
        start_op(8'h00, 8'hA5);
        calc_to_done("t2a", 16'h0000);
        back_to_idle("t2a");
        start_op(8'h0C, 8'h0D);
        calc_to_done("t2b", 16'h009C);
        back_to_idle("t2b");

        // 3: start re-pulsed in the 2nd CALC cycle
        start_op(8'h55, 8'h55);
        @(negedge clk);
        check("t3_k1", 64'(count_out), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_state", 64'(state_out), 64'd3);
        check("t3_err", 64'(err), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        check("t3_product", 64'(product), 64'h009C);
        @(negedge clk);
        check("t3_hold_state", 64'(state_out), 64'd3);
        check("t3_hold_err", 64'(err), 64'd1);
        check("t3_hold_busy", 64'(busy), 64'd0);
        start_op(8'h03, 8'h07);
        check("t3_errclr", 64'(err), 64'd0);
        calc_to_done("t3b", 16'h0015);
        back_to_idle("t3b");

        // 4: asynchronous reset between edges mid-CALC
        start_op(8'h12, 8'h34);
        @(negedge clk);
        #2 reset_a = 1'b1;
        #1;
        check("t4_product", 64'(product), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_err", 64'(err), 64'd0);
        check("t4_state", 64'(state_out), 64'd0);
        check("t4_count", 64'(count_out), 64'd0);
        #1 reset_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_idle_state", 64'(state_out), 64'd0);
            check("t4_idle_done", 64'(done), 64'd0);
        end

        // 5: back-to-back start in DONE cycle
        start_op(8'h0C, 8'h0D);
        calc_to_done("t5a", 16'h009C);
        dataa = 8'h10;
        datab = 8'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_nogap_state", 64'(state_out), 64'd1);
        calc_to_done("t5b", 16'h0100);
        back_to_idle("t5b");

        // 6: 16-bit operands, 16 CALC steps
        @(negedge clk);
        w_dataa = 16'hFFFF;
        w_datab = 16'hFFFF;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("t6_busy", 64'(w_busy), 64'd1);
            check("t6_count", 64'(w_count_out), 64'(k));
            @(negedge clk);
        end
        check("t6_done", 64'(w_done), 64'd1);
        check("t6_product", 64'(w_product), 64'hFFFE0001);
        check("t6_err", 64'(w_err), 64'd0);
        @(negedge clk);
        check("t6_idle", 64'(w_state_out), 64'd0);

`ifdef SEQ_MULT_SIGNED_MODE_EN
        // Signed: -128 x 127 = -16256
        @(negedge clk);
        signed_op = 1'b1;
        start_op(8'h80, 8'h7F);
        signed_op = 1'b0;
        calc_to_done("t7", 16'hC080);
        back_to_idle("t7");
        // Signed: -3 x -5 = 15
        @(negedge clk);
        signed_op = 1'b1;
        start_op(8'hFD, 8'hFB);
        signed_op = 1'b0;
        calc_to_done("t8", 16'h000F);
        back_to_idle("t8");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
